// File: rtl/cmd_decoder_pkg.sv
// cmd_decoder_pkg: opcodes, event indices, FSM states and direction mapping for cmd_decoder_fifo.
// The ACK state exists only when CMD_ACK_EN is defined.
package cmd_decoder_pkg;
  localparam logic [1:0] CLS_MOTOR = 2'b00;
  localparam logic [1:0] CLS_MAGNET = 2'b01;
  localparam logic [1:0] CLS_GAME = 2'b10;
  localparam logic [1:0] CLS_REQ = 2'b11;
  localparam logic [2:0] OP_SINGLE = 3'b000;
  localparam logic [2:0] OP_MULTI = 3'b001;
  localparam logic [5:0] OP_RESET_XY = 6'b111111;
  localparam logic [5:0] OP_HOFFSET = 6'b111001;
  localparam logic [5:0] OP_SCAN = 6'b111111;
  // to-play codes are the full bytes 0x85 / 0x86
  localparam logic [5:0] OP_BLACK_TO_PLAY = 6'b000101;
  localparam logic [5:0] OP_WHITE_TO_PLAY = 6'b000110;
  localparam logic [3:0] OP_DRAW_OFFER = 4'b1010;
  localparam logic [5:0] OP_BLACK_WINS = 6'b000001;
  localparam logic [5:0] OP_WHITE_WINS = 6'b000010;
  localparam logic [5:0] OP_DRAW = 6'b000011;
  localparam logic [5:0] OP_NORMAL_WAIT = 6'b000000;
  localparam logic [5:0] OP_MUST_JUMP = 6'b000001;
  localparam logic [5:0] OP_MORE_JUMPS = 6'b000010;
  localparam logic [5:0] OP_DID_NOT_MOVE = 6'b000011;
  localparam logic [5:0] OP_UNRECOVERABLE = 6'b111111;
  localparam int EVT_W = 19;
  typedef enum logic [4:0] {
    EV_RESET_XY, EV_HOFFSET, EV_MAG_ON, EV_MAG_OFF, EV_SCAN,
    EV_BLACK_TO_PLAY, EV_WHITE_TO_PLAY, EV_DRAW_OFFER,
    EV_BLACK_WINS, EV_WHITE_WINS, EV_DRAW,
    EV_NORMAL_WAIT, EV_MUST_JUMP, EV_MORE_JUMPS, EV_DID_NOT_MOVE, EV_UNRECOVERABLE,
    EV_RSVD16, EV_RSVD17, EV_RSVD18
  } evt_e;
  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, ARG, ISSUE, PULSE
`ifdef CMD_ACK_EN
    , ACK
`endif
  } state_e;
  function automatic logic [7:0] dir_onehot(input logic [2:0] c, input int n);
    return n == 4 ? 8'(1) << c[2:1] : 8'(1) << c;
  endfunction
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: DEPTH x 8 FIFO with combinational read; push+pop on empty passes din straight through.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic we, re;
  assign level = wp - rp;
  assign empty = level == '0;
  assign full = level[AW];
  assign we = push & (~full | pop);
  assign re = pop & (~empty | push);
  assign dout = empty ? din : mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (we) mem[wp[AW-1:0]] <= din;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (we) wp <= wp + 1'b1;
      if (re) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/cmd_decoder_fifo.sv
// cmd_decoder_fifo: edge-detected byte FIFO feeding a host command decoder FSM (moves + event pulses).
// Define CMD_ACK_EN to add the ack_byte/ack_valid/ack_ready acknowledge handshake.
module cmd_decoder_fifo
  import cmd_decoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIR_COUNT = 8,
  parameter int STEP_W = 8,
  parameter int PULSE_LEN = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          data_incoming,
  input  logic [7:0]                    dataStream,
  output logic                          move_valid,
  input  logic                          move_ready,
  output logic [DIR_COUNT-1:0]          move_dir,
  output logic [STEP_W-1:0]             move_steps,
  output logic [EVT_W-1:0]              evt,
  output logic                          bad_cmd,
  output logic                          overflow,
  input  logic                          clear_err,
`ifdef CMD_ACK_EN
  output logic [7:0]                    ack_byte,
  output logic                          ack_valid,
  input  logic                          ack_ready,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
`ifdef CMD_ACK_EN
  localparam state_e DONE_ST = ACK;
`else
  localparam state_e DONE_ST = IDLE;
`endif
  state_e state, state_d;
  logic prev, push, pop, full, empty, bad_set;
  logic [7:0] dout, cmd, dir8;
  logic [5:0] op;
  logic [2:0] dc;
  logic [STEP_W-1:0] steps;
  logic [DIR_COUNT-1:0] dir;
  logic [EVT_W-1:0] evt_q;
  logic [3:0] cnt;
  logic is_ev, is_single, is_multi, dir_ok;
  evt_e ev;
  assign push = data_incoming & ~prev;
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(dataStream),
    .dout(dout), .full(full), .empty(empty), .level(fifo_level)
  );
  assign op = cmd[5:0];
  assign dc = cmd[5:3];
  assign dir8 = dir_onehot(dc, DIR_COUNT);
  assign dir_ok = DIR_COUNT != 4 || !dc[0];
  assign is_single = cmd[7:6] == CLS_MOTOR && !is_ev && op[2:0] == OP_SINGLE;
  assign is_multi = cmd[7:6] == CLS_MOTOR && !is_ev && op[2:0] == OP_MULTI;
  always_comb begin
    is_ev = 1'b1;
    ev = EV_SCAN;
    case (cmd[7:6])
      CLS_MOTOR: begin
        is_ev = op == OP_RESET_XY || op == OP_HOFFSET;
        ev = op == OP_RESET_XY ? EV_RESET_XY : EV_HOFFSET;
      end
      CLS_MAGNET: ev = op[5] ? EV_MAG_ON : EV_MAG_OFF;
      CLS_GAME: begin
        if (op == OP_SCAN) ev = EV_SCAN;
        else if (op == OP_BLACK_TO_PLAY) ev = EV_BLACK_TO_PLAY;
        else if (op == OP_WHITE_TO_PLAY) ev = EV_WHITE_TO_PLAY;
        else if (op[5:2] == OP_DRAW_OFFER) ev = EV_DRAW_OFFER;
        else if (op == OP_BLACK_WINS) ev = EV_BLACK_WINS;
        else if (op == OP_WHITE_WINS) ev = EV_WHITE_WINS;
        else if (op == OP_DRAW) ev = EV_DRAW;
        else is_ev = 1'b0;
      end
      default: begin
        case (op)
          OP_NORMAL_WAIT: ev = EV_NORMAL_WAIT;
          OP_MUST_JUMP: ev = EV_MUST_JUMP;
          OP_MORE_JUMPS: ev = EV_MORE_JUMPS;
          OP_DID_NOT_MOVE: ev = EV_DID_NOT_MOVE;
          OP_UNRECOVERABLE: ev = EV_UNRECOVERABLE;
          default: is_ev = 1'b0;
        endcase
      end
    endcase
  end
  always_comb begin
    state_d = state;
    pop = 1'b0;
    bad_set = 1'b0;
    case (state)
      IDLE: state_d = empty ? IDLE : FETCH;
      FETCH: begin
        pop = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        bad_set = !(is_ev || is_multi || (is_single && dir_ok));
        state_d = is_ev ? PULSE : is_multi ? ARG : bad_set ? DONE_ST : ISSUE;
      end
      ARG: if (!empty) begin
        // direction of a multi-step move is validated only once its argument is consumed
        pop = 1'b1;
        bad_set = dout == 8'd0 || !dir_ok;
        state_d = bad_set ? DONE_ST : ISSUE;
      end
      ISSUE: state_d = move_ready ? DONE_ST : ISSUE;
      PULSE: state_d = cnt == 4'(PULSE_LEN - 1) ? DONE_ST : PULSE;
`ifdef CMD_ACK_EN
      ACK: state_d = ack_ready ? IDLE : ACK;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      prev <= 1'b0;
      cmd <= '0;
      steps <= '0;
      dir <= '0;
      evt_q <= '0;
      cnt <= '0;
      bad_cmd <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_d;
      prev <= data_incoming;
      bad_cmd <= bad_set;
      overflow <= (push & full & ~pop) | (overflow & ~clear_err);
      cnt <= state == PULSE ? cnt + 4'd1 : 4'd0;
      if (state == FETCH) cmd <= dout;
      if (state == DECODE) begin
        steps <= STEP_W'(1);
        dir <= dir8[DIR_COUNT-1:0];
        evt_q <= EVT_W'(1) << ev;
      end
      if (state == ARG && !empty) steps <= STEP_W'(dout);
    end
  end
  assign move_valid = state == ISSUE;
  assign move_dir = move_valid ? dir : '0;
  assign move_steps = move_valid ? steps : '0;
  assign evt = state == PULSE ? evt_q : '0;
`ifdef CMD_ACK_EN
  logic last_bad;
  always_ff @(posedge clk) begin
    if (!rst_n) last_bad <= 1'b0;
    else if (state == DECODE || state == ARG) last_bad <= bad_set;
  end
  assign ack_valid = state == ACK;
  assign ack_byte = ack_valid ? {1'b1, last_bad, cmd[5:0]} : 8'd0;
`endif
endmodule

// File: tb/tb_cmd_decoder_fifo.sv
// tb_cmd_decoder_fifo: scoreboard bench; u0 = depth 4 / pulse 3 / 8 dirs, u1 = 4 dirs, shared inputs.
module tb_cmd_decoder_fifo;
  import cmd_decoder_pkg::*;
  typedef struct packed {logic [1:0] k; logic [EVT_W-1:0] d; logic [7:0] a;} rec_t;
  localparam logic [1:0] K_MOVE = 2'd0, K_EVT = 2'd1, K_BAD = 2'd2;
  logic clk = 0, rst_n = 0, data_incoming = 0, move_ready = 0, clear_err = 0;
  logic [7:0] dataStream = 0;
  logic u0_mv, u0_bad, u0_ovf, u1_mv, u1_bad, u1_ovf;
  logic [7:0] u0_dir, u0_steps, u1_steps;
  logic [3:0] u1_dir, u1_lvl;
  logic [2:0] u0_lvl;
  logic [EVT_W-1:0] u0_evt, u1_evt;
  int total = 0, bad = 0;
  rec_t exp_q[$], obs_q[$];
  cmd_decoder_fifo #(.FIFO_DEPTH(4), .PULSE_LEN(3)) u0 (
    .clk(clk), .rst_n(rst_n), .data_incoming(data_incoming), .dataStream(dataStream),
    .move_valid(u0_mv), .move_ready(move_ready), .move_dir(u0_dir), .move_steps(u0_steps),
    .evt(u0_evt), .bad_cmd(u0_bad), .overflow(u0_ovf), .clear_err(clear_err), .fifo_level(u0_lvl)
  );
  cmd_decoder_fifo #(.DIR_COUNT(4)) u1 (
    .clk(clk), .rst_n(rst_n), .data_incoming(data_incoming), .dataStream(dataStream),
    .move_valid(u1_mv), .move_ready(move_ready), .move_dir(u1_dir), .move_steps(u1_steps),
    .evt(u1_evt), .bad_cmd(u1_bad), .overflow(u1_ovf), .clear_err(clear_err), .fifo_level(u1_lvl)
  );
  always #5 clk = ~clk;
  int ev_len = 0;
  logic [EVT_W-1:0] ev_val;
  always @(negedge clk) if (rst_n) begin
    if (u0_mv && move_ready) obs_q.push_back({K_MOVE, EVT_W'(u0_dir), u0_steps});
    if (u0_bad) obs_q.push_back({K_BAD, EVT_W'(0), 8'd0});
    if (u0_evt != '0) begin
      ev_val = u0_evt;
      ev_len++;
    end else if (ev_len != 0) begin
      obs_q.push_back({K_EVT, ev_val, 8'(ev_len)});
      ev_len = 0;
    end
  end
  function automatic rec_t mv(input logic [7:0] d, input logic [7:0] s);
    return {K_MOVE, EVT_W'(d), s};
  endfunction
  function automatic rec_t ev3(input int idx);
    return {K_EVT, EVT_W'(1) << idx, 8'd3};
  endfunction
  task automatic send_byte(input logic [7:0] b);
    data_incoming = 1;
    dataStream = b;
    @(posedge clk); #1;
    data_incoming = 0;
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if ({u0_mv, u0_bad, u0_ovf} !== 3'b0) begin bad++; $display("FAIL reset_flags got=%b exp=000", {u0_mv, u0_bad, u0_ovf}); end
    total++; if ({u0_dir, u0_steps} !== 16'h0) begin bad++; $display("FAIL reset_move got=%h exp=0", {u0_dir, u0_steps}); end
    total++; if (u0_evt !== '0) begin bad++; $display("FAIL reset_evt got=%h exp=0", u0_evt); end
    total++; if (u0_lvl !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", u0_lvl); end
    @(posedge clk); #1;
    rst_n = 1;
    repeat (2) @(posedge clk); #1;
  endtask
  task automatic test_single_move();
    rec_t e, o;
    move_ready = 0;
    data_incoming = 1;
    dataStream = 8'h10;
    exp_q.push_back(mv(8'h04, 8'd1));
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); @(negedge clk);
      total++; if (u0_mv !== (c == 3)) begin bad++; $display("FAIL latency_c%0d got=%b exp=%b", c, u0_mv, c == 3); end
    end
    total++; if ({u0_dir, u0_steps} !== {8'h04, 8'd1}) begin bad++; $display("FAIL single_dir_steps got=%h exp=0401", {u0_dir, u0_steps}); end
    @(posedge clk); #1;
    data_incoming = 0;
    move_ready = 1;
    @(negedge clk);
    total++; if (u0_mv !== 1'b1) begin bad++; $display("FAIL hold_valid got=%b exp=1", u0_mv); end
    @(posedge clk); @(negedge clk);
    total++; if (u0_mv !== 1'b0) begin bad++; $display("FAIL valid_drop got=%b exp=0", u0_mv); end
    repeat (10) @(posedge clk); #1;
    total++; if (u0_lvl !== 3'd0) begin bad++; $display("FAIL single_level got=%0d exp=0", u0_lvl); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : '1;
      total++; if (o !== e) begin bad++; $display("FAIL sb_single got=%h exp=%h", o, e); end
    end
    total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL sb_single_extra got=%0d exp=0", obs_q.size()); obs_q.delete(); end
  endtask
  task automatic test_multi_move();
    rec_t e, o;
    move_ready = 1;
    send_byte(8'h01); send_byte(8'h05);
    exp_q.push_back(mv(8'h01, 8'd5));
    repeat (6) @(posedge clk); #1;
    send_byte(8'h01); send_byte(8'h00);
    exp_q.push_back({K_BAD, EVT_W'(0), 8'd0});
    for (int i = 0; i < 300 && obs_q.size() < exp_q.size(); i++) @(posedge clk);
    repeat (8) @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : '1;
      total++; if (o !== e) begin bad++; $display("FAIL sb_multi got=%h exp=%h", o, e); end
    end
    total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL sb_multi_extra got=%0d exp=0", obs_q.size()); obs_q.delete(); end
  endtask
  task automatic test_events();
    rec_t e, o;
    logic [7:0] b [12];
    rec_t x [12];
    b = '{8'h86, 8'hC5, 8'h3F, 8'h39, 8'h60, 8'h40, 8'hFF, 8'hA9, 8'h83, 8'hC3, 8'h02, 8'hBF};
    x = '{ev3(EV_WHITE_TO_PLAY), {K_BAD, EVT_W'(0), 8'd0}, ev3(EV_RESET_XY), ev3(EV_HOFFSET),
          ev3(EV_MAG_ON), ev3(EV_MAG_OFF), ev3(EV_UNRECOVERABLE), ev3(EV_DRAW_OFFER),
          ev3(EV_DRAW), ev3(EV_DID_NOT_MOVE), {K_BAD, EVT_W'(0), 8'd0}, ev3(EV_SCAN)};
    move_ready = 1;
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(x[i]);
      send_byte(b[i]);
      repeat (8) @(posedge clk); #1;
    end
    for (int i = 0; i < 300 && obs_q.size() < exp_q.size(); i++) @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : '1;
      total++; if (o !== e) begin bad++; $display("FAIL sb_events got=%h exp=%h", o, e); end
    end
    total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL sb_events_extra got=%0d exp=0", obs_q.size()); obs_q.delete(); end
  endtask
  task automatic test_overflow();
    rec_t e, o;
    logic [7:0] b [6];
    b = '{8'h00, 8'h18, 8'h28, 8'h38, 8'h08, 8'h08};
    move_ready = 0;
    send_byte(8'h10);
    exp_q.push_back(mv(8'h04, 8'd1));
    repeat (5) @(posedge clk); #1;
    foreach (b[i]) send_byte(b[i]);
    exp_q.push_back(mv(8'h01, 8'd1));
    exp_q.push_back(mv(8'h08, 8'd1));
    exp_q.push_back(mv(8'h20, 8'd1));
    exp_q.push_back(mv(8'h80, 8'd1));
    @(negedge clk);
    total++; if (u0_lvl !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d exp=4", u0_lvl); end
    total++; if (u0_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", u0_ovf); end
    @(posedge clk); #1;
    clear_err = 1;
    @(posedge clk); #1;
    clear_err = 0;
    @(negedge clk);
    total++; if (u0_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", u0_ovf); end
    @(posedge clk); #1;
    clear_err = 1;
    data_incoming = 1;
    dataStream = 8'h08;
    @(posedge clk); #1;
    clear_err = 0;
    data_incoming = 0;
    @(negedge clk);
    total++; if (u0_ovf !== 1'b1) begin bad++; $display("FAIL ovf_clear_vs_set got=%b exp=1", u0_ovf); end
    @(posedge clk); #1;
    clear_err = 1;
    @(posedge clk); #1;
    clear_err = 0;
    move_ready = 1;
    for (int i = 0; i < 300 && obs_q.size() < exp_q.size(); i++) @(posedge clk);
    repeat (10) @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : '1;
      total++; if (o !== e) begin bad++; $display("FAIL sb_overflow got=%h exp=%h", o, e); end
    end
    total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL sb_overflow_extra got=%0d exp=0", obs_q.size()); obs_q.delete(); end
    total++; if ({u0_ovf, u0_lvl} !== 4'd0) begin bad++; $display("FAIL ovf_final got=%b exp=0000", {u0_ovf, u0_lvl}); end
    repeat (60) @(posedge clk); #1;
  endtask
  task automatic test_dir4();
    rec_t e, o;
    move_ready = 1;
    data_incoming = 1;
    dataStream = 8'h08;
    exp_q.push_back(mv(8'h02, 8'd1));
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); @(negedge clk);
      total++; if (u1_bad !== (c == 3)) begin bad++; $display("FAIL dir4_bad_c%0d got=%b exp=%b", c, u1_bad, c == 3); end
    end
    @(posedge clk); #1;
    data_incoming = 0;
    repeat (6) @(posedge clk); #1;
    data_incoming = 1;
    dataStream = 8'h30;
    exp_q.push_back(mv(8'h40, 8'd1));
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); @(negedge clk);
      total++; if (u1_mv !== (c == 3)) begin bad++; $display("FAIL dir4_valid_c%0d got=%b exp=%b", c, u1_mv, c == 3); end
    end
    total++; if (u1_dir !== 4'b1000) begin bad++; $display("FAIL dir4_west got=%b exp=1000", u1_dir); end
    @(posedge clk); #1;
    data_incoming = 0;
    for (int i = 0; i < 300 && obs_q.size() < exp_q.size(); i++) @(posedge clk);
    repeat (8) @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : '1;
      total++; if (o !== e) begin bad++; $display("FAIL sb_dir4 got=%h exp=%h", o, e); end
    end
    total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL sb_dir4_extra got=%0d exp=0", obs_q.size()); obs_q.delete(); end
  endtask
  task automatic test_reset_issue();
    logic seen = 0;
    move_ready = 0;
    send_byte(8'h10);
    repeat (3) @(posedge clk); #1;
    send_byte(8'h00);
    send_byte(8'h3F);
    @(negedge clk);
    total++; if ({u0_mv, u0_lvl} !== {1'b1, 3'd2}) begin bad++; $display("FAIL pre_reset got=%b exp=1010", {u0_mv, u0_lvl}); end
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); @(negedge clk);
    total++; if ({u0_mv, u0_lvl} !== 4'd0) begin bad++; $display("FAIL mid_reset got=%b exp=0000", {u0_mv, u0_lvl}); end
    @(posedge clk); #1;
    rst_n = 1;
    move_ready = 1;
    repeat (20) begin
      @(negedge clk);
      seen = seen | u0_mv | (u0_evt != '0) | u0_bad;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL stale_cmd got=%b exp=0", seen); end
    total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL stale_obs got=%0d exp=0", obs_q.size()); end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_single_move();
    test_multi_move();
    test_events();
    test_overflow();
    test_dir4();
    test_reset_issue();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
